// File: rtl/construtor_caminho_multiporta_pkg.sv
// Shared types and defaults for the predecessor memory / path builder.
// Included by the storage sub-module and the walking FSM.
package construtor_caminho_multiporta_pkg;

  localparam int ADDR_WIDTH_DEF   = 8;
  localparam int NUM_PORTS_DEF    = 8;
  localparam int MAX_PATH_LEN_DEF = 64;

  localparam logic MODO_REVERSO = 1'b0;
  localparam logic MODO_DIRETO  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WALK_REV,
    S_WALK_FWD,
    S_POP,
    S_DONE,
    S_ERRO
  } estado_t;

endpackage

// File: rtl/anterior_mem_multiporta.sv
// Predecessor storage: flop array plus valid bitmap, NUM_PORTS writes,
// one asynchronous read port returning {valid, anterior}.
module anterior_mem_multiporta
  import construtor_caminho_multiporta_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_PORTS  = NUM_PORTS_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic [NUM_PORTS-1:0]          write_en,
  input  logic [ADDR_WIDTH*NUM_PORTS-1:0] write_addr,
  input  logic [ADDR_WIDTH*NUM_PORTS-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0]         read_addr,
  output logic                          read_valid,
  output logic [ADDR_WIDTH-1:0]         read_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      valid_q;

  // Later iterations override earlier ones: highest port wins.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (write_en[p] && !clear) begin
        mem[write_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] <=
          write_data[p*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (clear) begin
      valid_q <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (write_en[p]) begin
          valid_q[write_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] <= 1'b1;
        end
      end
    end
  end

  assign read_valid = valid_q[read_addr];
  assign read_data  = mem[read_addr];

endmodule

// File: rtl/construtor_caminho_multiporta.sv
// Path reconstruction: walks predecessors destino->fonte and streams
// the path, reversed directly or forward through an in-line LIFO.
module construtor_caminho_multiporta
  import construtor_caminho_multiporta_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int NUM_PORTS    = NUM_PORTS_DEF,
  parameter int MAX_PATH_LEN = MAX_PATH_LEN_DEF,
  localparam int LEN_WIDTH   = $clog2(MAX_PATH_LEN + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear_in,
  input  logic [NUM_PORTS-1:0]            write_en_in,
  input  logic [ADDR_WIDTH*NUM_PORTS-1:0] write_addr_in,
  input  logic [ADDR_WIDTH*NUM_PORTS-1:0] write_data_in,
  input  logic                            start_in,
  input  logic                            mode_in,
  input  logic [ADDR_WIDTH-1:0]           fonte_in,
  input  logic [ADDR_WIDTH-1:0]           destino_in,
  output logic [ADDR_WIDTH-1:0]           path_data_out,
  output logic                            path_valid_out,
  output logic                            path_last_out,
  input  logic                            path_ready_in,
  output logic                            busy_out,
  output logic                            pronto_out,
  output logic                            erro_out,
  output logic [LEN_WIDTH-1:0]            path_len_out
);

  localparam int PTR_W = $clog2(MAX_PATH_LEN);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_MAX  = LEN_WIDTH'(MAX_PATH_LEN);
  localparam logic [LEN_WIDTH-1:0] LEN_FULL = LEN_WIDTH'(MAX_PATH_LEN - 1);

  estado_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] cur_q, cur_d;
  logic [ADDR_WIDTH-1:0] fonte_q, fonte_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  sp_q, sp_d;
  logic                  erro_q, erro_d;

  logic                  push;
  logic [ADDR_WIDTH-1:0] lifo [MAX_PATH_LEN];
  logic [PTR_W-1:0]      push_idx;
  logic [PTR_W-1:0]      top_idx;

  logic                  rd_valid;
  logic [ADDR_WIDTH-1:0] rd_data;

  anterior_mem_multiporta #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_PORTS  (NUM_PORTS)
  ) u_mem (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear_in),
    .write_en   (write_en_in & {NUM_PORTS{state_q == S_IDLE}}),
    .write_addr (write_addr_in),
    .write_data (write_data_in),
    .read_addr  (cur_q),
    .read_valid (rd_valid),
    .read_data  (rd_data)
  );

  assign push_idx = sp_q[PTR_W-1:0];
  assign top_idx  = PTR_W'(sp_q - LEN_ONE);

  always_comb begin
    state_d        = state_q;
    cur_d          = cur_q;
    fonte_d        = fonte_q;
    len_d          = len_q;
    sp_d           = sp_q;
    erro_d         = erro_q;
    push           = 1'b0;
    path_valid_out = 1'b0;
    path_data_out  = '0;
    path_last_out  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_in) begin
          fonte_d = fonte_in;
          cur_d   = destino_in;
          len_d   = '0;
          erro_d  = 1'b0;
          state_d = (mode_in == MODO_DIRETO) ? S_WALK_FWD
                                             : S_WALK_REV;
        end
      end
      S_WALK_REV: begin
        path_valid_out = 1'b1;
        path_data_out  = cur_q;
        path_last_out  = (cur_q == fonte_q);
        if (path_ready_in) begin
          len_d = len_q + LEN_ONE;
          if (cur_q == fonte_q) begin
            state_d = S_DONE;
          end else if (!rd_valid || len_d == LEN_MAX) begin
            state_d = S_ERRO;
          end else begin
            cur_d = rd_data;
          end
        end
      end
      S_WALK_FWD: begin
        if (cur_q == fonte_q) begin
          push    = 1'b1;
          sp_d    = sp_q + LEN_ONE;
          state_d = S_POP;
        end else if (!rd_valid || sp_q == LEN_FULL) begin
          state_d = S_ERRO;
        end else begin
          push  = 1'b1;
          sp_d  = sp_q + LEN_ONE;
          cur_d = rd_data;
        end
      end
      S_POP: begin
        path_valid_out = 1'b1;
        path_data_out  = lifo[top_idx];
        path_last_out  = (sp_q == LEN_ONE);
        if (path_ready_in) begin
          sp_d  = sp_q - LEN_ONE;
          len_d = len_q + LEN_ONE;
          if (sp_q == LEN_ONE) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_ERRO: begin
        erro_d  = 1'b1;
        sp_d    = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Soft clear overrides whatever the walk decided this cycle.
    if (clear_in) begin
      state_d = S_IDLE;
      sp_d    = '0;
      erro_d  = 1'b0;
      push    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      fonte_q <= '0;
      len_q   <= '0;
      sp_q    <= '0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      fonte_q <= fonte_d;
      len_q   <= len_d;
      sp_q    <= sp_d;
      erro_q  <= erro_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) lifo[push_idx] <= cur_q;
  end

  assign busy_out     = (state_q != S_IDLE);
  assign pronto_out   = (state_q == S_DONE);
  assign erro_out     = erro_q;
  assign path_len_out = len_q;

endmodule
